// File: rtl/md_sched_if.sv
// E-stage / MD-datapath signal bundle for md_sched.
// MD_SCHED_STAT_EN adds the stall/issue statistics counters to the bundle.
interface md_sched_if;
  logic        e_valid;
  logic [3:0]  e_op;
  logic        e_req;
  logic        d_md_use;
  logic        md_start;
  logic [3:0]  md_op;
  logic        md_we_lo;
  logic        md_we_hi;
  logic        md_commit;
  logic        busy;
  logic        stall;
  logic        proto_err;
`ifdef MD_SCHED_STAT_EN
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;

  modport master (
    output e_valid, e_op, e_req, d_md_use,
    input  md_start, md_op, md_we_lo, md_we_hi, md_commit, busy, stall, proto_err,
    input  stall_cnt, issue_cnt
  );
  modport slave (
    input  e_valid, e_op, e_req, d_md_use,
    output md_start, md_op, md_we_lo, md_we_hi, md_commit, busy, stall, proto_err,
    output stall_cnt, issue_cnt
  );
`else
  modport master (
    output e_valid, e_op, e_req, d_md_use,
    input  md_start, md_op, md_we_lo, md_we_hi, md_commit, busy, stall, proto_err
  );
  modport slave (
    input  e_valid, e_op, e_req, d_md_use,
    output md_start, md_op, md_we_lo, md_we_hi, md_commit, busy, stall, proto_err
  );
`endif
endinterface

// File: rtl/md_sched.sv
// Multiply/divide issue, latency and HI/LO hazard controller.
// Optional MD_SCHED_STAT_EN adds saturating stall and issue counters.
module md_sched #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       md_op_q, md_op_d;
  logic             proto_err_q, proto_err_d;

  logic op_calc, op_mul, op_any;
  logic iss, start, we_lo, we_hi, commit, busy, stall;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_op_d     = md_op_q;
    start       = 1'b0;
    we_lo       = 1'b0;
    we_hi       = 1'b0;
    commit      = 1'b0;
    op_calc     = (md.e_op >= 4'd1) && (md.e_op <= 4'd4);
    op_mul      = (md.e_op == 4'd1) || (md.e_op == 4'd2);
    op_any      = (md.e_op >= 4'd1) && (md.e_op <= 4'd6);
    busy        = (state_q != S_IDLE);
    iss         = md.e_valid & ~md.e_req & ~busy;

    unique case (state_q)
      S_IDLE: begin
        if (iss) begin
          if (op_calc) begin
            start   = 1'b1;
            md_op_d = md.e_op;
            cnt_d   = op_mul ? MUL_LOAD : DIV_LOAD;
            state_d = S_RUN;
          end else if (md.e_op == 4'd5) begin
            we_lo = 1'b1;
          end else if (md.e_op == 4'd6) begin
            we_hi = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_ONE) state_d = S_DONE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      S_DONE: begin
        commit  = 1'b1;
        md_op_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // DONE is still busy, so a D-stage MFHI/MFLO waits until after the commit edge.
    stall       = md.d_md_use & (busy | (iss & op_calc));
    proto_err_d = proto_err_q | (md.e_valid & op_any & busy);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      md_op_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_op_q     <= md_op_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign md.md_start  = start;
  assign md.md_op     = md_op_q;
  assign md.md_we_lo  = we_lo;
  assign md.md_we_hi  = we_hi;
  assign md.md_commit = commit;
  assign md.busy      = busy;
  assign md.stall     = stall;
  assign md.proto_err = proto_err_q;

`ifdef MD_SCHED_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (start && (issue_cnt_q != '1)) issue_cnt_d = issue_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign md.stall_cnt = stall_cnt_q;
  assign md.issue_cnt = issue_cnt_q;
`endif

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Issue/hazard controller for the multi-cycle multiply/divide unit and its HI/LO registers in the 5-stage pipeline.
- Accepts the MD-class instruction in the E stage and issues start, or HI/LO write strobes, to the MD datapath.
- Counts out the operation latency and pulses commit when the result is due.
- Generates the D-stage stall for any MD-class instruction that would collide with an in-flight operation; honours the exception/interrupt request so flushed instructions never issue.

Parameters:
- MUL_LAT, 5, cycles from start to commit for MULT/MULTU (must be >= 2)
- DIV_LAT, 10, cycles from start to commit for DIV/DIVU (must be >= 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- e_valid  in  1  E-stage instruction valid
- e_op  in  4  E-stage MD op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTLO, 6 MTHI, 7 MFLO, 8 MFHI, 9-15 none
- e_req  in  1  exception/interrupt flush of the E-stage instruction this cycle
- d_md_use  in  1  D-stage instruction is any op 1-8
- md_start  out  1  one-cycle start pulse to the datapath
- md_op  out  4  op latched with md_start; held until commit
- md_we_lo  out  1  write LO from rs this cycle (MTLO)
- md_we_hi  out  1  write HI from rs this cycle (MTHI)
- md_commit  out  1  one-cycle pulse: load HI/LO from the datapath result
- busy  out  1  state != IDLE
- stall  out  1  freeze PC/F/D and bubble E
- proto_err  out  1  sticky: MD op seen in E while not IDLE

Behaviour:
- Reset: state IDLE, cnt 0, md_op 0, proto_err 0; all pulse outputs 0. Reset mid-operation aborts it with no commit.
- Issue condition: iss = e_valid & !e_req & state==IDLE.
- States:
  - IDLE: if iss and e_op in 1-4: md_start=1 (combinational, same cycle), latch md_op, cnt <= LAT-1 (MUL_LAT for 1-2, DIV_LAT for 3-4), go RUN. If iss and e_op 5/6: md_we_lo/md_we_hi=1 that cycle, stay IDLE. Ops 7/8 and 0/9-15 produce no action.
  - RUN: if cnt==1 go DONE, else cnt--.
  - DONE: md_commit=1 for exactly one cycle, md_op <= 0, go IDLE.
- Latency: start at cycle T, then commit at T+LAT; busy high from T+1 to T+LAT inclusive.
- Stall: stall = d_md_use & (busy | (iss & e_op in 1-4)).
  - MFHI/MFLO in D during DONE is stalled, so it reads HI/LO only after the commit edge.
  - Stall is independent of e_req except through iss.
- e_req: blocks issue in the same cycle only. It never cancels a RUN/DONE operation, because that instruction already retired past E.
- e_valid & e_op in 1-6 while not IDLE: ignored (no start, no write) and proto_err <= 1. This only happens if stall is disobeyed.
- Back-to-back: a second MULT can issue at the earliest in the cycle after DONE.
- Writes are mutually exclusive: md_we_* never coincide with md_commit, since writes require IDLE.

Optional Feature:
- Macro MD_SCHED_STAT_EN.
- When defined:
  - Adds output stall_cnt [31:0]: counts cycles with stall=1; saturates at 0xFFFFFFFF; cleared by reset.
  - Adds output issue_cnt [31:0]: counts md_start pulses; saturates at 0xFFFFFFFF; cleared by reset.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- MULT issue (e_valid=1, e_op=1) at cycle 0: md_start@0, busy cycles 1-5, md_commit@5 only, idle @6.
- DIVU at cycle 0 with d_md_use=1 (MFLO) held: stall=1 on cycles 0-10 and 0 @11; md_commit@10.
- MTHI with e_req=1: md_we_hi=0, no state change. Repeat with e_req=0: md_we_hi=1 for 1 cycle, busy stays 0.
- DIV issued, reset driven low at cycle 4 (async, mid-cycle): busy/md_op cleared immediately; no md_commit at cycle 10.
- Force e_op=2 with e_valid=1 during RUN: no md_start, proto_err=1 and stays 1 until reset.
- With MD_SCHED_STAT_EN: MULT then DIV back-to-back with continuous d_md_use=1 yields issue_cnt=2 and stall_cnt equal to the observed stall cycles.
